// File: rtl/mskaes_rnd_pkg.sv
// Shared types and constants for the masked-AES randomness dispatcher.
package mskaes_rnd_pkg;

  // Width of the pop counter that schedules automatic reseeds
  localparam int unsigned CNT_W = 16;

  // Dispatcher control states
  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_RESEED_REQ  = 2'd1,
    ST_RESEED_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/mskaes_rnd_dispatch_fifo.sv
// First-word-fall-through FIFO for randomness words. The head word is
// zero-masked when empty so that stale storage never reaches the core.
module rnd_fifo #(
  parameter int RND_W = 240,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       push_i,
  input  logic [RND_W-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [RND_W-1:0]           rdata_o,
  output logic                       valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [RND_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_en;
  logic             pop_en;

  assign full_o  = (level_q == LW'(DEPTH));
  assign valid_o = (level_q != '0);

  // Internal guards make overflow and underflow impossible regardless of caller
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & valid_o;

  // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of two)
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push_en) wptr_d = wptr_q + AW'(1);
    if (pop_en)  rptr_d = rptr_q + AW'(1);
    case ({push_en, pop_en})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wptr_q] <= wdata_i;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  assign rdata_o = valid_o ? mem_q[rptr_q] : '0;
  assign level_o = level_q;

endmodule

// File: rtl/mskaes_rnd_dispatch.sv
// Buffers PRNG words for the masked AES core and schedules PRNG reseeds,
// either on request or after a fixed number of consumed words.
module mskaes_rnd_dispatch
  import mskaes_rnd_pkg::*;
#(
  parameter int RND_W         = 240,
  parameter int DEPTH         = 4,
  parameter int RESEED_PERIOD = 1024
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [RND_W-1:0]           prng_rnd,
  input  logic                       prng_valid,
  output logic                       prng_ready,
  input  logic                       prng_busy,
  output logic                       prng_start_reseed,
  input  logic                       reseed_req,
  input  logic                       core_req,
  output logic [RND_W-1:0]           core_rnd,
  output logic                       core_rnd_valid,
  output logic                       starve,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam logic [CNT_W-1:0] PERIOD = CNT_W'(RESEED_PERIOD);

  state_e           state_q;
  logic             start_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic             reseed_due;
  logic             enter_req;

  // Pushes are only accepted while running; buffered words stay poppable always
  assign prng_ready = ~fifo_full & (state_q == ST_RUN);
  assign push       = prng_valid & prng_ready;
  assign pop        = core_req & core_rnd_valid;
  assign starve     = core_req & ~core_rnd_valid;

  assign reseed_due = (RESEED_PERIOD != 0) && (cnt_q >= PERIOD);
  assign enter_req  = (state_q == ST_RUN) && (reseed_req || reseed_due);

  rnd_fifo #(
    .RND_W (RND_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .push_i  (push),
    .wdata_i (prng_rnd),
    .pop_i   (pop),
    .rdata_o (core_rnd),
    .valid_o (core_rnd_valid),
    .full_o  (fifo_full),
    .level_o (level)
  );

  // Pop counter next-state: cleared on reseed entry, saturating otherwise
  always_comb begin
    cnt_d = cnt_q;
    if (enter_req)                cnt_d = '0;
    else if (pop && cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
  end

  // Pop counter register
  always_ff @(posedge clk) begin
    if (!nrst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Reseed handshake FSM with a registered start strobe; reset never waits on busy
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= ST_RUN;
      start_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (enter_req) begin
            state_q <= ST_RESEED_REQ;
            start_q <= 1'b1;
          end
        end
        ST_RESEED_REQ: begin
          if (prng_busy) begin
            state_q <= ST_RESEED_WAIT;
            start_q <= 1'b0;
          end
        end
        ST_RESEED_WAIT: begin
          if (!prng_busy) state_q <= ST_RUN;
        end
        default: begin
          state_q <= ST_RUN;
          start_q <= 1'b0;
        end
      endcase
    end
  end

  assign prng_start_reseed = start_q;

endmodule

// File: tb/tb_mskaes_rnd_dispatch.sv
// Directed checks plus a scoreboard soak for the randomness dispatcher.
module tb_mskaes_rnd_dispatch;

  localparam int RW    = 16;
  localparam int DEP   = 4;
  localparam int PER   = 8;
  localparam int LVW   = $clog2(DEP+1);

  logic           clk;
  logic           nrst;
  logic [RW-1:0]  prng_rnd;
  logic           prng_valid;
  logic           prng_ready;
  logic           prng_busy;
  logic           prng_start_reseed;
  logic           reseed_req;
  logic           core_req;
  logic [RW-1:0]  core_rnd;
  logic           core_rnd_valid;
  logic           starve;
  logic [LVW-1:0] level;

  int n_assert = 0;
  int n_fail   = 0;

  mskaes_rnd_dispatch #(
    .RND_W         (RW),
    .DEPTH         (DEP),
    .RESEED_PERIOD (PER)
  ) dut (
    .clk               (clk),
    .nrst              (nrst),
    .prng_rnd          (prng_rnd),
    .prng_valid        (prng_valid),
    .prng_ready        (prng_ready),
    .prng_busy         (prng_busy),
    .prng_start_reseed (prng_start_reseed),
    .reseed_req        (reseed_req),
    .core_req          (core_req),
    .core_rnd          (core_rnd),
    .core_rnd_valid    (core_rnd_valid),
    .starve            (starve),
    .level             (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst       = 1'b0;
    prng_valid = 1'b0;
    prng_rnd   = '0;
    core_req   = 1'b0;
    reseed_req = 1'b0;
    prng_busy  = 1'b0;
    cyc();
    cyc();
    nrst = 1'b1;
  endtask

  logic [RW-1:0] sb_q[$];
  logic [RW-1:0] exp_w;
  int            busy_cnt;
  logic          do_push;
  logic          do_pop;

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    nrst = 1'b0;
    #1;
    $display("tb: reset state");
    chk("rst_ready", 32'(prng_ready), 32'd1);
    chk("rst_valid", 32'(core_rnd_valid), 32'd0);
    chk("rst_rnd", 32'(core_rnd), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_start", 32'(prng_start_reseed), 32'd0);
    chk("rst_starve0", 32'(starve), 32'd0);
    core_req = 1'b1;
    #1;
    chk("rst_starve1", 32'(starve), 32'd1);
    core_req = 1'b0;
    cyc();
    nrst = 1'b1;

    // ---------------- fill to full ----------------
    do_reset();
    $display("tb: fill to full");
    prng_valid = 1'b1;
    for (int i = 0; i < DEP; i++) begin
      prng_rnd = RW'(16'h0010 + i);
      #1;
      chk("fill_ready", 32'(prng_ready), 32'd1);
      chk("fill_level", 32'(level), 32'(i));
      cyc();
    end
    #1;
    chk("full_level", 32'(level), 32'd4);
    chk("full_ready", 32'(prng_ready), 32'd0);
    chk("full_head", 32'(core_rnd), 32'h10);
    core_req = 1'b1;
    prng_rnd = 16'h0099;
    #1;
    chk("full_pop_ready", 32'(prng_ready), 32'd0);
    cyc();
    prng_valid = 1'b0;
    core_req   = 1'b0;
    #1;
    chk("full_pop_level", 32'(level), 32'd3);
    chk("full_pop_head", 32'(core_rnd), 32'h11);

    // ---------------- ordering ----------------
    do_reset();
    $display("tb: ordering");
    for (int k = 0; k < 3; k++) begin
      prng_valid = 1'b1;
      prng_rnd   = RW'(16'h00A1 + k);
      cyc();
    end
    prng_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      core_req = 1'b1;
      #1;
      chk("order_data", 32'(core_rnd), 32'(16'h00A1 + k));
      chk("order_valid", 32'(core_rnd_valid), 32'd1);
      cyc();
    end
    core_req = 1'b0;
    #1;
    chk("order_empty_rnd", 32'(core_rnd), 32'd0);
    chk("order_empty_valid", 32'(core_rnd_valid), 32'd0);
    chk("order_empty_level", 32'(level), 32'd0);

    // ---------------- starve, no bypass ----------------
    $display("tb: starve");
    core_req   = 1'b1;
    prng_valid = 1'b1;
    prng_rnd   = 16'h005C;
    #1;
    chk("starve_flag", 32'(starve), 32'd1);
    chk("starve_valid", 32'(core_rnd_valid), 32'd0);
    chk("starve_rnd", 32'(core_rnd), 32'd0);
    cyc();
    core_req   = 1'b0;
    prng_valid = 1'b0;
    #1;
    chk("starve_next_valid", 32'(core_rnd_valid), 32'd1);
    chk("starve_next_rnd", 32'(core_rnd), 32'h5C);
    chk("starve_next_level", 32'(level), 32'd1);

    // ---------------- automatic reseed ----------------
    do_reset();
    $display("tb: auto reseed");
    for (int k = 0; k < PER; k++) begin
      prng_valid = 1'b1;
      prng_rnd   = RW'(16'h0030 + k);
      cyc();
      prng_valid = 1'b0;
      core_req   = 1'b1;
      #1;
      chk("auto_pop_data", 32'(core_rnd), 32'(16'h0030 + k));
      cyc();
      core_req = 1'b0;
    end
    #1;
    chk("auto_not_yet", 32'(prng_start_reseed), 32'd0);
    chk("auto_ready_run", 32'(prng_ready), 32'd1);
    prng_valid = 1'b1;
    prng_rnd   = 16'h0044;
    cyc();
    prng_rnd = 16'h0077;
    #1;
    chk("auto_start", 32'(prng_start_reseed), 32'd1);
    chk("auto_ready_req", 32'(prng_ready), 32'd0);
    chk("auto_level_req", 32'(level), 32'd1);
    chk("auto_head_req", 32'(core_rnd), 32'h44);
    cyc();
    #1;
    chk("auto_start_hold", 32'(prng_start_reseed), 32'd1);
    chk("auto_push_blocked", 32'(level), 32'd1);
    prng_valid = 1'b0;
    prng_busy  = 1'b1;
    cyc();
    #1;
    chk("auto_wait_start", 32'(prng_start_reseed), 32'd0);
    chk("auto_wait_ready", 32'(prng_ready), 32'd0);
    core_req = 1'b1;
    #1;
    chk("auto_wait_valid", 32'(core_rnd_valid), 32'd1);
    cyc();
    core_req = 1'b0;
    #1;
    chk("auto_wait_pop_level", 32'(level), 32'd0);
    chk("auto_wait_ready2", 32'(prng_ready), 32'd0);
    prng_busy = 1'b0;
    cyc();
    #1;
    chk("auto_back_ready", 32'(prng_ready), 32'd1);
    chk("auto_back_start", 32'(prng_start_reseed), 32'd0);
    cyc();
    #1;
    chk("auto_cnt_cleared", 32'(prng_start_reseed), 32'd0);

    // ---------------- manual reseed held through a reseed ----------------
    $display("tb: manual reseed retrigger");
    reseed_req = 1'b1;
    cyc();
    #1;
    chk("man_start", 32'(prng_start_reseed), 32'd1);
    prng_busy = 1'b1;
    cyc();
    #1;
    chk("man_wait_start", 32'(prng_start_reseed), 32'd0);
    prng_busy = 1'b0;
    cyc();
    #1;
    chk("man_run_ready", 32'(prng_ready), 32'd1);
    chk("man_run_start", 32'(prng_start_reseed), 32'd0);
    cyc();
    #1;
    chk("man_retrigger", 32'(prng_start_reseed), 32'd1);
    reseed_req = 1'b0;

    // ---------------- reset during reseed wait ----------------
    do_reset();
    $display("tb: reset mid-reseed");
    prng_valid = 1'b1;
    prng_rnd   = 16'h0055;
    reseed_req = 1'b1;
    cyc();
    prng_valid = 1'b0;
    reseed_req = 1'b0;
    #1;
    chk("mid_level", 32'(level), 32'd1);
    chk("mid_start", 32'(prng_start_reseed), 32'd1);
    prng_busy = 1'b1;
    cyc();
    #1;
    chk("mid_wait_ready", 32'(prng_ready), 32'd0);
    nrst = 1'b0;
    cyc();
    nrst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(prng_ready), 32'd1);
    chk("mid_rst_start", 32'(prng_start_reseed), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_valid", 32'(core_rnd_valid), 32'd0);
    chk("mid_rst_rnd", 32'(core_rnd), 32'd0);
    cyc();
    #1;
    chk("mid_rst_stay_run", 32'(prng_ready), 32'd1);
    prng_busy = 1'b0;

    // ---------------- random soak with scoreboard ----------------
    do_reset();
    $display("tb: random soak");
    busy_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        prng_busy = (busy_cnt != 0);
      end else if (prng_start_reseed) begin
        prng_busy = 1'b1;
        busy_cnt  = 3;
      end
      prng_valid = 1'($urandom_range(1, 0));
      prng_rnd   = RW'($urandom);
      core_req   = 1'($urandom_range(1, 0));
      #1;
      chk("soak_level", 32'(level), 32'(sb_q.size()));
      chk("soak_valid", 32'(core_rnd_valid), 32'(sb_q.size() != 0));
      do_push = prng_valid & prng_ready;
      do_pop  = core_req & (sb_q.size() != 0);
      if (do_pop) begin
        exp_w = sb_q[0];
        chk("soak_data", 32'(core_rnd), 32'(exp_w));
      end
      cyc();
      if (do_pop)  void'(sb_q.pop_front());
      if (do_push) sb_q.push_back(prng_rnd);
    end
    prng_valid = 1'b0;
    core_req   = 1'b0;
    #1;
    chk("soak_final_level", 32'(level), 32'(sb_q.size()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
